// File: rtl/matrix_mac_engine.sv
// Matrix multiply engine: holds operand matrices A and B, computes C = A*B with one MAC per cycle,
// and streams C out row-major over a valid/ready result port.
module matrix_mac_engine #(
  parameter int DATA_W    = 4,
  parameter int MAX_ELEMS = 8,
  parameter int ADDR_W    = 3,
  parameter int ACC_W     = 2*DATA_W+3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_we,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [3:0]        R1,
  input  logic [3:0]        C1,
  input  logic [3:0]        R2,
  input  logic [3:0]        C2,
  input  logic              start,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [3:0]        res_row,
  output logic [3:0]        res_col,
  output logic              res_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam logic [7:0] MAX_ELEMS_8 = 8'(MAX_ELEMS);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0]   a_mem [MAX_ELEMS];
  logic [DATA_W-1:0]   b_mem [MAX_ELEMS];
  logic [3:0]          r1_q, c1_q, c2_q;
  logic [3:0]          i_q, j_q, k_q;
  logic [ACC_W-1:0]    acc_q, acc_sum;
  logic [ADDR_W-1:0]   a_idx, b_idx;
  logic [DATA_W-1:0]   a_val, b_val;
  logic [2*DATA_W-1:0] prod;
  logic [7:0]          area_a, area_b;
  logic                dims_ok, k_last, row_last, col_last;

  // Geometry check uses the live dimension inputs because it is evaluated on the start cycle itself.
  assign area_a  = {4'd0, R1} * {4'd0, C1};
  assign area_b  = {4'd0, R2} * {4'd0, C2};
  assign dims_ok = (C1 == R2) && (R1 != 4'd0) && (C1 != 4'd0) && (R2 != 4'd0) && (C2 != 4'd0)
                   && (area_a <= MAX_ELEMS_8) && (area_b <= MAX_ELEMS_8);

  assign a_idx    = ADDR_W'(i_q * c1_q + k_q);
  assign b_idx    = ADDR_W'(k_q * c2_q + j_q);
  assign a_val    = a_mem[a_idx];
  assign b_val    = b_mem[b_idx];
  assign prod     = (2*DATA_W)'(a_val) * (2*DATA_W)'(b_val);
  assign acc_sum  = acc_q + ACC_W'(prod);
  assign k_last   = (k_q == c1_q - 4'd1);
  assign row_last = (i_q == r1_q - 4'd1);
  assign col_last = (j_q == c2_q - 4'd1);

  // Operand storage is loadable only while idle and is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (ld_we && (state == S_IDLE) && (int'(ld_addr) < MAX_ELEMS)) begin
      if (ld_sel) b_mem[ld_addr] <= ld_data;
      else        a_mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Result port: res_valid rises at the end of an element's MAC run; res_data/row/col/last hold
  // until a cycle with res_valid && res_ready, which is the only transfer; res_ready alone does nothing.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && dims_ok) state_nxt = S_MAC;
      S_MAC:  if (k_last) state_nxt = S_EMIT;
      S_EMIT: if (res_ready) state_nxt = res_last ? S_DONE : S_MAC;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r1_q      <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
      res_col   <= '0;
      res_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (dims_ok) begin
              err   <= 1'b0;
              r1_q  <= R1;
              c1_q  <= C1;
              c2_q  <= C2;
              i_q   <= '0;
              j_q   <= '0;
              k_q   <= '0;
              acc_q <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_MAC: begin
          if (k_last) begin
            res_data  <= acc_sum;
            res_row   <= i_q;
            res_col   <= j_q;
            res_last  <= row_last && col_last;
            res_valid <= 1'b1;
            k_q       <= '0;
          end else begin
            acc_q <= acc_sum;
            k_q   <= k_q + 4'd1;
          end
        end
        S_EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            acc_q     <= '0;
            if (!res_last) begin
              if (col_last) begin
                j_q <= '0;
                i_q <= i_q + 4'd1;
              end else begin
                j_q <= j_q + 4'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == S_MAC) || (state == S_EMIT);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule
